// File: rtl/demux_scan_seq8.sv
// Serialises an accepted 8-bit word onto a 1:8 demux, one channel at a time, with a programmable hold.
// Optional SCAN_MASK_EN adds Chan_mask so that only the channels whose mask bit is set are visited.
module demux_scan_seq8 #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Data_in,
`ifdef SCAN_MASK_EN
  input  logic [7:0] Chan_mask,
`endif
  input  logic       Data_valid,
  output logic       Data_ready,
  output logic       Serial_out,
  output logic [2:0] Sel,
  output logic       Enable,
  output logic       Busy,
  output logic       Frame_done
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] data_reg, data_next;
  logic [2:0] chan_reg, chan_next;
  logic [7:0] hold_reg, hold_next;
  logic       done_reg, done_next;
  logic       serial_reg, serial_next;
  logic [7:0] scan_mask;
  logic [7:0] accept_mask;
  logic [3:0] first_hit;
  logic [3:0] next_hit;

  // Returns {found, index} for the lowest set mask bit at or above lo.
  function automatic logic [3:0] find_chan(input logic [7:0] m, input int lo);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

`ifdef SCAN_MASK_EN
  logic [7:0] mask_reg, mask_next;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) mask_reg <= 8'h00;
    else          mask_reg <= mask_next;
  end

  assign scan_mask   = mask_reg;
  assign accept_mask = Chan_mask;
`else
  assign scan_mask   = 8'hFF;
  assign accept_mask = 8'hFF;
`endif

  assign first_hit = find_chan(accept_mask, 0);
  assign next_hit  = find_chan(scan_mask, int'(chan_reg) + 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      data_reg   <= 8'h00;
      chan_reg   <= 3'd0;
      hold_reg   <= 8'h00;
      done_reg   <= 1'b0;
      serial_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      chan_reg   <= chan_next;
      hold_reg   <= hold_next;
      done_reg   <= done_next;
      serial_reg <= serial_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    chan_next  = chan_reg;
    hold_next  = hold_reg;
    done_next  = 1'b0;
`ifdef SCAN_MASK_EN
    mask_next  = mask_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (Data_valid) begin
          data_next = Data_in;
          hold_next = 8'h00;
`ifdef SCAN_MASK_EN
          mask_next = Chan_mask;
`endif
          if (first_hit[3]) begin
            chan_next  = first_hit[2:0];
            state_next = SCAN;
          end else begin
            // Empty mask: the frame is complete without presenting any channel.
            done_next = 1'b1;
          end
        end
      end
      SCAN: begin
        if (hold_reg == HOLD_LAST) begin
          hold_next = 8'h00;
          if (next_hit[3]) begin
            chan_next = next_hit[2:0];
          end else begin
            chan_next  = 3'd0;
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Serial_out is registered from the next-state values so it toggles only at clock edges.
  always_comb begin
    serial_next = 1'b0;
    if (state_next == SCAN) serial_next = data_next[chan_next];
  end

  assign Data_ready = (state_reg == IDLE);
  assign Busy       = (state_reg == SCAN);
  assign Enable     = (state_reg == SCAN);
  assign Sel        = chan_reg;
  assign Serial_out = serial_reg;
  assign Frame_done = done_reg;

endmodule
